ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/ctrl_pipe_pkg.sv | 15 +
 rtl/pipe_stage_reg.sv | 35 +++
 rtl/ctrl_pipeline.sv | 88 ++++++++
 tb/tb_ctrl_pipeline.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-word pipeline: stage indices, default widths
// and the bubble encoding.
package ctrl_pipe_pkg;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  localparam int DEFAULT_W  = 16;
  localparam int DEFAULT_CW = 8;

  localparam logic [DEFAULT_W-1:0] BUBBLE_CTRL  = '0;
  localparam logic                 BUBBLE_VALID = 1'b0;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: holds a masked control word and its valid flag.
module pipe_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         R,
  input  logic         LE,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic [W-1:0] mask,
  output logic [W-1:0] dout,
  output logic         dout_valid
);

  always_ff @(posedge clk) begin
    if (R) begin
      dout       <= W'(BUBBLE_CTRL);
      dout_valid <= BUBBLE_VALID;
    end else if (LE && load) begin
      if (bubble || !din_valid) begin
        // An invalid stage always carries an all-zero control word.
        dout       <= W'(BUBBLE_CTRL);
        dout_valid <= BUBBLE_VALID;
      end else begin
        dout       <= din & mask;
        dout_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-word pipeline with stall, flush, NOP select and a saturating
// bubble counter.
module ctrl_pipeline
  import ctrl_pipe_pkg::*;
#(
  parameter int                  W           = DEFAULT_W,
  parameter int                  STAGES      = 3,
  parameter int                  FLUSH_DEPTH = 1,
  parameter logic [STAGES*W-1:0] MASK        = '1,
  parameter int                  CW          = DEFAULT_CW
) (
  input  logic                clk,
  input  logic                R,
  input  logic                LE,
  input  logic [W-1:0]        in_ctrl,
  input  logic                in_valid,
  input  logic                SS,
  input  logic                stall,
  input  logic                flush,
  output logic [STAGES*W-1:0] stage_ctrl,
  output logic [STAGES-1:0]   stage_valid,
  output logic [CW-1:0]       bubble_cnt
);

  logic [W-1:0] stg_ctrl [STAGES];
  logic         stg_load [STAGES];
  logic         stg_bub  [STAGES];

  // Priority: flush > stall > normal advance; LE and R gate inside the stages.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_load[k] = 1'b1;
      stg_bub[k]  = 1'b0;
    end
    if (flush) begin
      for (int k = 0; k < STAGES; k++) begin
        if (k < FLUSH_DEPTH) stg_bub[k] = 1'b1;
      end
    end else if (stall) begin
      stg_load[EX] = 1'b0;
      stg_bub[MEM] = 1'b1;
    end else begin
      stg_bub[EX] = SS | ~in_valid;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W-1:0] din;
    logic         din_valid;

    if (k == EX) begin : g_first
      assign din       = in_ctrl;
      assign din_valid = in_valid;
    end else begin : g_next
      assign din       = stg_ctrl[k-1];
      assign din_valid = stage_valid[k-1];
    end

    pipe_stage_reg #(
      .W (W)
    ) u_stage (
      .clk        (clk),
      .R          (R),
      .LE         (LE),
      .load       (stg_load[k]),
      .bubble     (stg_bub[k]),
      .din        (din),
      .din_valid  (din_valid),
      .mask       (MASK[k*W +: W]),
      .dout       (stg_ctrl[k]),
      .dout_valid (stage_valid[k])
    );

    assign stage_ctrl[k*W +: W] = stg_ctrl[k];
  end

  logic bubble_event;
  assign bubble_event = SS | stall | flush | ~in_valid;

  always_ff @(posedge clk) begin
    if (R) begin
      bubble_cnt <= '0;
    end else if (LE && bubble_event && (bubble_cnt != {CW{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench: instance a has a narrowed WB mask, instance b uses the
// default mask with a 4-bit bubble counter.
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        R, LE, in_valid, SS, stall, flush;
  logic [15:0] in_ctrl;
  logic [47:0] a_ctrl, b_ctrl;
  logic [2:0]  a_valid, b_valid;
  logic [7:0]  a_cnt;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(
    .W           (16),
    .STAGES      (3),
    .FLUSH_DEPTH (1),
    .MASK        ({16'h000F, 16'hFFFF, 16'hFFFF}),
    .CW          (8)
  ) dut_a (
    .clk         (clk),
    .R           (R),
    .LE          (LE),
    .in_ctrl     (in_ctrl),
    .in_valid    (in_valid),
    .SS          (SS),
    .stall       (stall),
    .flush       (flush),
    .stage_ctrl  (a_ctrl),
    .stage_valid (a_valid),
    .bubble_cnt  (a_cnt)
  );

  ctrl_pipeline #(
    .W           (16),
    .STAGES      (3),
    .FLUSH_DEPTH (1),
    .CW          (4)
  ) dut_b (
    .clk         (clk),
    .R           (R),
    .LE          (LE),
    .in_ctrl     (in_ctrl),
    .in_valid    (in_valid),
    .SS          (SS),
    .stall       (stall),
    .flush       (flush),
    .stage_ctrl  (b_ctrl),
    .stage_valid (b_valid),
    .bubble_cnt  (b_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    R = 1'b1; LE = 1'b1; SS = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_ctrl = 16'h0000;
    step();
    R = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1; LE = 1'b1; SS = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_ctrl = 16'hFFFF;
    step();
    step();
    checks++;
    if (a_ctrl !== 48'h0) begin
      errors++; $display("FAIL reset_a_ctrl got %h want %h", a_ctrl, 48'h0);
    end
    checks++;
    if (a_valid !== 3'b000) begin
      errors++; $display("FAIL reset_a_valid got %b want %b", a_valid, 3'b000);
    end
    checks++;
    if (a_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_a_cnt got %0d want 0", a_cnt);
    end
    checks++;
    if (b_ctrl !== 48'h0 || b_valid !== 3'b000 || b_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_b got %h/%b/%0d want 0/000/0", b_ctrl, b_valid, b_cnt);
    end
    R = 1'b0;
  endtask

  task automatic test_propagation();
    do_reset();
    in_ctrl = 16'h00A5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (a_ctrl[15:0] !== 16'h00A5 || a_cnt !== 8'd0) begin
      errors++;
      $display("FAIL prop_ex got %h cnt %0d want 00a5 cnt 0", a_ctrl[15:0], a_cnt);
    end
    step();
    checks++;
    if (a_ctrl[31:16] !== 16'h00A5 || a_cnt !== 8'd1) begin
      errors++;
      $display("FAIL prop_mem got %h cnt %0d want 00a5 cnt 1", a_ctrl[31:16], a_cnt);
    end
    step();
    checks++;
    if (a_ctrl[47:32] !== 16'h0005) begin
      errors++; $display("FAIL prop_wb got %h want 0005", a_ctrl[47:32]);
    end
    checks++;
    if (a_cnt !== 8'd2) begin
      errors++; $display("FAIL prop_cnt got %0d want 2", a_cnt);
    end
    checks++;
    if (a_valid !== 3'b100 || a_ctrl[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL prop_bubbles got %b/%h want 100/00000000", a_valid, a_ctrl[31:0]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    in_valid = 1'b1; in_ctrl = 16'h0022;
    step();
    in_ctrl = 16'h0011;
    step();
    checks++;
    if (b_ctrl[31:0] !== 32'h0022_0011 || b_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stall_setup got %h cnt %0d want 00220011 cnt 0", b_ctrl[31:0], b_cnt);
    end
    stall = 1'b1; SS = 1'b1; in_ctrl = 16'h00EE;
    step();
    stall = 1'b0; SS = 1'b0;
    checks++;
    if (b_ctrl !== 48'h0022_0000_0011) begin
      errors++; $display("FAIL stall_ctrl got %h want 002200000011", b_ctrl);
    end
    checks++;
    if (b_valid !== 3'b101 || b_cnt !== 4'd1) begin
      errors++;
      $display("FAIL stall_valid_cnt got %b/%0d want 101/1", b_valid, b_cnt);
    end
    checks++;
    if (a_ctrl[47:32] !== 16'h0002) begin
      errors++; $display("FAIL stall_wb_mask got %h want 0002", a_ctrl[47:32]);
    end
  endtask

  task automatic test_flush_stall();
    do_reset();
    in_valid = 1'b1; in_ctrl = 16'h0033;
    step();
    in_ctrl = 16'h0022;
    step();
    in_ctrl = 16'h0011;
    step();
    checks++;
    if (b_ctrl !== 48'h0033_0022_0011 || b_valid !== 3'b111) begin
      errors++;
      $display("FAIL fs_setup got %h/%b want 003300220011/111", b_ctrl, b_valid);
    end
    flush = 1'b1; stall = 1'b1; in_ctrl = 16'h00EE;
    step();
    flush = 1'b0; stall = 1'b0;
    checks++;
    if (b_ctrl !== 48'h0022_0011_0000) begin
      errors++; $display("FAIL fs_ctrl got %h want 002200110000", b_ctrl);
    end
    checks++;
    if (b_valid !== 3'b110 || b_cnt !== 4'd1) begin
      errors++; $display("FAIL fs_valid_cnt got %b/%0d want 110/1", b_valid, b_cnt);
    end
  endtask

  // Runs directly after test_flush_stall and relies on its final state.
  task automatic test_freeze();
    LE = 1'b0; flush = 1'b1; SS = 1'b1; stall = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (b_ctrl !== 48'h0022_0011_0000 || b_valid !== 3'b110) begin
      errors++;
      $display("FAIL freeze_state got %h/%b want 002200110000/110", b_ctrl, b_valid);
    end
    checks++;
    if (b_cnt !== 4'd1 || a_cnt !== 8'd1) begin
      errors++; $display("FAIL freeze_cnt got %0d/%0d want 1/1", b_cnt, a_cnt);
    end
    LE = 1'b1; flush = 1'b0; SS = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    R = 1'b1; stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_ctrl = 16'h0077;
    step();
    checks++;
    if (b_ctrl !== 48'h0 || b_valid !== 3'b000 || b_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid got %h/%b/%0d want 0/000/0", b_ctrl, b_valid, b_cnt);
    end
    R = 1'b0; stall = 1'b0; flush = 1'b0; in_ctrl = 16'h0044;
    step();
    checks++;
    if (b_ctrl !== 48'h0000_0000_0044 || b_valid !== 3'b001 || b_cnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_post got %h/%b/%0d want 000000000044/001/0", b_ctrl, b_valid, b_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    SS = 1'b1; in_valid = 1'b1; in_ctrl = 16'h1234;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13) begin
        checks++;
        if (b_cnt !== 4'd14) begin
          errors++; $display("FAIL sat_pre got %0d want 14", b_cnt);
        end
      end
      if (i == 14) begin
        checks++;
        if (b_cnt !== 4'd15) begin
          errors++; $display("FAIL sat_reach got %0d want 15", b_cnt);
        end
      end
    end
    SS = 1'b0;
    checks++;
    if (b_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_hold got %0d want 15", b_cnt);
    end
    checks++;
    if (a_cnt !== 8'd20 || b_valid !== 3'b000) begin
      errors++; $display("FAIL sat_wide got %0d/%b want 20/000", a_cnt, b_valid);
    end
  endtask

  initial begin
    R = 1'b1; LE = 1'b1; SS = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_ctrl = 16'h0000;
    test_reset();
    test_propagation();
    test_stall();
    test_flush_stall();
    test_freeze();
    test_reset_mid_stall();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
